// File: rtl/mux_nt1_stream_pkg.sv
// Shared definitions for the N:1 registered stream multiplexer.
// Latency: n/a (constants and elaboration-time helpers only).
// Backpressure: n/a.
// Contents: select-mode encodings, channel-count limit, parameter sanity helper.
package mux_nt1_stream_pkg;

  // Select mode encodings driven on the 'mode' port.
  localparam logic MUX_MODE_FIXED = 1'b0;
  localparam logic MUX_MODE_RR    = 1'b1;

  // Largest supported channel count.
  localparam int MUX_MAX_N = 16;

  // SEL_W may be wider than clog2(N) so an out-of-range select can be
  // presented and rejected; it may never be narrower.
  function automatic bit params_ok(input int n, input int sel_w);
    return (n >= 2) && (n <= MUX_MAX_N) && (sel_w >= $clog2(n));
  endfunction

endpackage

// File: rtl/mux_nt1_stream_rr_pick.sv
// Rotating priority encoder: first asserted req at or after 'start', wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller gates the result.
// Ports: req[N] requests, start[SEL_W] scan origin (< N),
//        idx[SEL_W] winning channel, found = at least one request present.
module rr_pick_n #(
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] start,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  logic [2*N-1:0] req2;
  logic [2*N-1:0] mask;
  logic [2*N-1:0] req_m;

  // Doubling the vector turns the wrap-around scan into a linear one:
  // positions below 'start' in the lower copy are masked off, and the upper
  // copy supplies the wrapped channels.
  always_comb begin
    req2  = {req, req};
    mask  = '0;
    for (int j = 0; j < 2*N; j++) begin
      mask[j] = (j >= int'(start));
    end
    req_m = req2 & mask;

    idx   = '0;
    found = 1'b0;
    // Scan downward so the lowest set position is the last one written.
    for (int j = 2*N-1; j >= 0; j--) begin
      if (req_m[j]) begin
        found = 1'b1;
        idx   = (j >= N) ? SEL_W'(j - N) : SEL_W'(j);
      end
    end
  end

endmodule

// File: rtl/mux_nt1_stream.sv
// N:1 WIDTH-bit stream mux with one-entry output register; FIXED or round-robin select.
// Latency: 1 cycle from input transfer to out_valid; 1 word/cycle sustained.
// Backpressure: out_valid && !out_ready stalls the register and drops every in_ready.
// Ports: clk/rst_n clock and async active-low reset; mode (0 FIXED, 1 RR); sel FIXED channel;
//        in_data/in_valid/in_ready per-channel stream (channel i at [i*WIDTH +: WIDTH]);
//        out_data/out_valid/out_ready output stream; out_idx source channel of out_data.
module mux_nt1_stream
  import mux_nt1_stream_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   out_idx
);

  if (!params_ok(N, SEL_W)) begin : g_param_err
    $error("mux_nt1_stream: N must be 2..16 and SEL_W >= clog2(N)");
  end

  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q,  out_data_d;
  logic [SEL_W-1:0]   out_idx_q,   out_idx_d;
  logic [SEL_W-1:0]   rr_ptr_q,    rr_ptr_d;

  logic [SEL_W-1:0]   rr_idx;
  logic               rr_found;
  logic               fixed_vld;
  logic [SEL_W-1:0]   pick;
  logic               pick_ok;
  logic [WIDTH-1:0]   pick_data;
  logic               can_load;
  logic               load;

  rr_pick_n #(.N(N), .SEL_W(SEL_W)) u_rr_pick (
    .req   (in_valid),
    .start (rr_ptr_q),
    .idx   (rr_idx),
    .found (rr_found)
  );

  always_comb begin
    // A select value >= N matches no channel, so fixed_vld stays low.
    fixed_vld = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel == SEL_W'(i)) fixed_vld = in_valid[i];
    end

    if (mode == MUX_MODE_RR) begin
      pick    = rr_idx;
      pick_ok = rr_found;
    end else begin
      pick    = sel;
      pick_ok = fixed_vld;
    end

    pick_data = in_data[0 +: WIDTH];
    for (int i = 0; i < N; i++) begin
      if (pick == SEL_W'(i)) pick_data = in_data[i*WIDTH +: WIDTH];
    end

    // The register can take a word whenever it is empty or being drained now.
    can_load = !out_valid_q || out_ready;
    load     = can_load && pick_ok;

    for (int i = 0; i < N; i++) begin
      in_ready[i] = rst_n && load && (pick == SEL_W'(i));
    end

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = pick_data;
      out_idx_d   = pick;
      // Only RR grants move the pointer, so it survives FIXED periods.
      if (mode == MUX_MODE_RR) begin
        rr_ptr_d = (pick == SEL_W'(N-1)) ? '0 : pick + SEL_W'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_mux_nt1_stream.sv
module tb_mux_nt1_stream;

  localparam int W  = 64;
  localparam int N  = 4;
  localparam int SW = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           mode = 1'b0;
  logic [SW-1:0]  sel = '0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_valid = '0;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [SW-1:0]  out_idx;

  int total = 0;
  int bad   = 0;

  localparam logic [W-1:0] D0 = 64'h0000_0000_0000_00A0;
  localparam logic [W-1:0] D1 = 64'h0000_0000_0000_00B1;
  localparam logic [W-1:0] D2 = 64'h0000_0000_DEAD_BEEF;
  localparam logic [W-1:0] D3 = 64'h0000_0000_0000_00D3;

  mux_nt1_stream #(.WIDTH(W), .N(N), .SEL_W(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         m_vld = 1'b0;
  logic [W-1:0] m_dat = '0;
  int         m_idx = 0;
  int         m_ptr = 0;

  // Which channel the rules select right now, and whether it is grantable.
  function automatic void model_pick(output int p, output bit ok);
    p  = 0;
    ok = 1'b0;
    if (mode == 1'b0) begin
      p = int'(sel);
      if (p < N) ok = in_valid[p];
    end else begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (!ok && in_valid[c]) begin
          p  = c;
          ok = 1'b1;
        end
      end
    end
  endfunction

  function automatic logic [N-1:0] model_ready();
    int p;
    bit ok;
    logic [N-1:0] r;
    r = '0;
    model_pick(p, ok);
    if (rst_n && ok && (!m_vld || out_ready)) r[p] = 1'b1;
    return r;
  endfunction

  int upd_p;
  bit upd_ok;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld = 1'b0;
      m_dat = '0;
      m_idx = 0;
      m_ptr = 0;
    end else begin
      model_pick(upd_p, upd_ok);
      if (upd_ok && (!m_vld || out_ready)) begin
        m_vld = 1'b1;
        m_dat = in_data[upd_p*W +: W];
        m_idx = upd_p;
        if (mode) m_ptr = (upd_p + 1) % N;
      end else if (out_ready) begin
        m_vld = 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("cyc_in_ready",  in_ready,  model_ready());
    chk("cyc_out_valid", out_valid, m_vld);
    chk("cyc_out_data",  out_data,  m_dat);
    chk("cyc_out_idx",   out_idx,   SW'(m_idx));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int rr_exp [6];
    int sk_exp [3];
    rr_exp = '{0, 1, 2, 3, 0, 1};
    sk_exp = '{0, 2, 0};
    in_data = {D3, D2, D1, D0};

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("idle_valid", out_valid, 1'b0);
    chk("idle_ptr_ready", in_ready, 4'b0000);

    // FIXED basic
    mode = 1'b0; sel = 3'd2; in_valid = 4'b1111; out_ready = 1'b1;
    #1 chk("fx_ready", in_ready, 4'b0100);
    cyc();
    chk("fx_valid", out_valid, 1'b1);
    chk("fx_data", out_data, 64'hDEAD_BEEF);
    chk("fx_idx", out_idx, 3'd2);
    sel = 3'd7;
    #1 chk("fx_sel7_ready", in_ready, 4'b0000);
    cyc();
    chk("fx_drain_valid", out_valid, 1'b0);
    chk("fx_hold_data", out_data, 64'hDEAD_BEEF);
    cyc();

    // RR fairness and wrap
    mode = 1'b1; sel = 3'd0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("rr_valid", out_valid, 1'b1);
      chk("rr_idx", out_idx, SW'(rr_exp[k]));
    end

    // RR skip: bring pointer to 3, then only channels 0 and 2 request
    in_valid = 4'b0100;
    cyc();
    chk("skip_pre_idx", out_idx, 3'd2);
    in_valid = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("skip_idx", out_idx, SW'(sk_exp[k]));
    end

    // Backpressure: hold channel-0 word for 5 cycles
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1 chk("bp_ready", in_ready, 4'b0000);
      cyc();
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_idx", out_idx, 3'd0);
      chk("bp_data", out_data, D0);
    end
    out_ready = 1'b1;
    #1 chk("rel_ready", in_ready, 4'b0100);
    cyc();
    chk("rel_valid1", out_valid, 1'b1);
    chk("rel_idx1", out_idx, 3'd2);
    chk("rel_data1", out_data, D2);
    cyc();
    chk("rel_valid2", out_valid, 1'b1);
    chk("rel_idx2", out_idx, 3'd0);

    // Mode switch: pointer to 2, three FIXED words, back to RR
    in_valid = 4'b0010;
    cyc();
    chk("ms_pre_idx", out_idx, 3'd1);
    mode = 1'b0; sel = 3'd0; in_valid = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("ms_fixed_idx", out_idx, 3'd0);
      chk("ms_fixed_valid", out_valid, 1'b1);
    end
    mode = 1'b1;
    cyc();
    chk("ms_rr_idx", out_idx, 3'd2);
    chk("ms_rr_data", out_data, D2);

    // Asynchronous reset while holding a valid word
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 64'h0);
    chk("rst_idx", out_idx, 3'd0);
    chk("rst_ready", in_ready, 4'b0000);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("post_rst_idx0", out_idx, 3'd0);
    cyc();
    chk("post_rst_idx1", out_idx, 3'd1);
    repeat (3) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
